// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive safety checker for a two-signal traffic light controller. Each clock
// it decodes both one-hot light codes, tracks each signal's state and dwell
// time, and flags illegal codes, conflicting right-of-way, illegal sequencing,
// bad dwell times and stuck states. It never drives the light buses.
//
// Parameters:
//   GREEN_MIN    minimum consecutive GREEN samples before GREEN may be left
//   YELLOW_TIME  exact number of consecutive YELLOW samples required
//   MAX_DWELL    dwell count at which a state is reported stuck
//
// Ports:
//   clk             system clock, rising-edge sampling
//   rst             asynchronous active-high reset
//   signal1_light   light code of signal 1 (001 GREEN, 010 YELLOW, 100 RED)
//   signal2_light   light code of signal 2, same encoding
//   monitor_valid   both signals have had a legal baseline sample since reset
//   err_encoding    pulse: illegal code sampled on either signal
//   err_conflict    pulse: both codes legal and neither is RED
//   err_transition  pulse: illegal state change on either signal
//   err_dwell       pulse: GREEN left early or YELLOW not exactly YELLOW_TIME
//   err_stuck       pulse: a state's dwell reached MAX_DWELL
//   err_sticky      OR of all pulses, held until reset
//   first_err_code  first error since reset (0 none, 1..5 as the pulses above)
//   phase_count     count of signal 1 legal RED->GREEN transitions (wraps)
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int GREEN_MIN   = 3,
    parameter int YELLOW_TIME = 2,
    parameter int MAX_DWELL   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  signal1_light,
    input  logic [2:0]  signal2_light,
    output logic        monitor_valid,
    output logic        err_encoding,
    output logic        err_conflict,
    output logic        err_transition,
    output logic        err_dwell,
    output logic        err_stuck,
    output logic        err_sticky,
    output logic [2:0]  first_err_code,
    output logic [15:0] phase_count
);

    localparam int DW = $clog2(MAX_DWELL + 1);

    typedef enum logic [1:0] {
        ST_INVALID,
        ST_GREEN,
        ST_YELLOW,
        ST_RED
    } light_state_t;

    typedef logic [DW-1:0] dwell_t;

    localparam dwell_t GREEN_MIN_D   = DW'(GREEN_MIN);
    localparam dwell_t YELLOW_TIME_D = DW'(YELLOW_TIME);
    localparam dwell_t MAX_DWELL_D   = DW'(MAX_DWELL);
    localparam dwell_t DWELL_ONE     = DW'(1);

    // Result of one tracker update: next state/dwell plus the violations it saw.
    typedef struct packed {
        light_state_t state;
        dwell_t       dwell;
        logic         legal;
        logic         is_red;
        logic         enc;
        logic         trans;
        logic         dwl;
        logic         stuck;
    } track_t;

    function automatic track_t track_step(input logic [2:0]   code,
                                          input light_state_t cur,
                                          input dwell_t       dwell);
        track_t       r;
        light_state_t sampled;
        dwell_t       dwell_inc;
        r         = '0;
        r.state   = cur;
        r.dwell   = dwell;
        dwell_inc = dwell + DWELL_ONE;
        case (code)
            3'b001:  sampled = ST_GREEN;
            3'b010:  sampled = ST_YELLOW;
            3'b100:  sampled = ST_RED;
            default: sampled = ST_INVALID;
        endcase
        r.legal  = (sampled != ST_INVALID);
        r.is_red = (sampled == ST_RED);

        if (!r.legal) begin
            r.enc   = 1'b1;
            r.state = ST_INVALID;
            r.dwell = '0;
        end else if (cur == ST_INVALID) begin
            // First legal sample after reset or an encoding error: baseline only.
            r.state = sampled;
            r.dwell = DWELL_ONE;
        end else if (sampled == cur) begin
            // Saturate so the stuck pulse fires once per state visit.
            if (dwell != MAX_DWELL_D) begin
                r.dwell = dwell_inc;
                r.stuck = (dwell_inc == MAX_DWELL_D);
            end
        end else begin
            if ((cur == ST_GREEN  && sampled == ST_YELLOW) ||
                (cur == ST_YELLOW && sampled == ST_RED)    ||
                (cur == ST_RED    && sampled == ST_GREEN)) begin
                r.dwl = (cur == ST_GREEN  && dwell <  GREEN_MIN_D) ||
                        (cur == ST_YELLOW && dwell != YELLOW_TIME_D);
            end else begin
                r.trans = 1'b1;
            end
            r.state = sampled;
            r.dwell = DWELL_ONE;
        end
        return r;
    endfunction

    light_state_t s1_state, s2_state;
    dwell_t       s1_dwell, s2_dwell;

    track_t     t1, t2;
    logic       conflict_now;
    logic       r2g_now;
    logic [4:0] err_now;
    logic [2:0] code_now;

    // NOTE: every variable assigned here gets a value on every path, so no
    // latch is inferred; track_step defaults its whole result up front.
    always_comb begin
        t1           = track_step(signal1_light, s1_state, s1_dwell);
        t2           = track_step(signal2_light, s2_state, s2_dwell);
        conflict_now = t1.legal && t2.legal && !t1.is_red && !t2.is_red;
        r2g_now      = (s1_state == ST_RED) && (signal1_light == 3'b001);
        err_now      = {t1.stuck | t2.stuck, t1.dwl | t2.dwl,
                        t1.trans | t2.trans, conflict_now, t1.enc | t2.enc};
        // Lowest error code wins when several fire on the same edge.
        code_now = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (err_now[i]) begin
                code_now = 3'(i + 1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_state       <= ST_INVALID;
            s2_state       <= ST_INVALID;
            s1_dwell       <= '0;
            s2_dwell       <= '0;
            monitor_valid  <= 1'b0;
            err_encoding   <= 1'b0;
            err_conflict   <= 1'b0;
            err_transition <= 1'b0;
            err_dwell      <= 1'b0;
            err_stuck      <= 1'b0;
            err_sticky     <= 1'b0;
            first_err_code <= 3'd0;
            phase_count    <= 16'd0;
        end else begin
            s1_state       <= t1.state;
            s2_state       <= t2.state;
            s1_dwell       <= t1.dwell;
            s2_dwell       <= t2.dwell;
            err_encoding   <= err_now[0];
            err_conflict   <= err_now[1];
            err_transition <= err_now[2];
            err_dwell      <= err_now[3];
            err_stuck      <= err_now[4];
            if (t1.state != ST_INVALID && t2.state != ST_INVALID) begin
                monitor_valid <= 1'b1;
            end
            if (|err_now) begin
                err_sticky <= 1'b1;
                if (!err_sticky) begin
                    first_err_code <= code_now;
                end
            end
            if (r2g_now) begin
                phase_count <= phase_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor. A behavioural model tracks each
// signal as "last legal code + run length" and derives every output from the
// light rules; a negedge process compares all outputs against it each cycle.
// Literal checks at key points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    localparam int GREEN_MIN   = 3;
    localparam int YELLOW_TIME = 2;
    localparam int MAX_DWELL   = 64;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  s1 = R;
    logic [2:0]  s2 = G;
    logic        monitor_valid, err_encoding, err_conflict, err_transition;
    logic        err_dwell, err_stuck, err_sticky;
    logic [2:0]  first_err_code;
    logic [15:0] phase_count;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .GREEN_MIN   (GREEN_MIN),
        .YELLOW_TIME (YELLOW_TIME),
        .MAX_DWELL   (MAX_DWELL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .signal1_light  (s1),
        .signal2_light  (s2),
        .monitor_valid  (monitor_valid),
        .err_encoding   (err_encoding),
        .err_conflict   (err_conflict),
        .err_transition (err_transition),
        .err_dwell      (err_dwell),
        .err_stuck      (err_stuck),
        .err_sticky     (err_sticky),
        .first_err_code (first_err_code),
        .phase_count    (phase_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: per signal, last legal code (0 = none) and its run length.
    int          prev [2];
    int          run  [2];
    logic        exp_enc, exp_conf, exp_trans, exp_dwell, exp_stuck;
    logic        exp_valid, exp_sticky;
    logic [2:0]  exp_first;
    logic [15:0] exp_phase;
    bit          cmp_en = 1'b0;

    function automatic bit is_legal(input logic [2:0] c);
        return (c == G) || (c == Y) || (c == R);
    endfunction

    task automatic reset_model();
        prev = '{0, 0};
        run  = '{0, 0};
        {exp_enc, exp_conf, exp_trans, exp_dwell, exp_stuck} = '0;
        exp_valid  = 1'b0;
        exp_sticky = 1'b0;
        exp_first  = 3'd0;
        exp_phase  = 16'd0;
    endtask

    task automatic model_signal(input int idx, input logic [2:0] c,
                                output bit enc, output bit trans,
                                output bit dw, output bit stuck, output bit r2g);
        int succ;
        {enc, trans, dw, stuck, r2g} = '0;
        if (!is_legal(c)) begin
            enc = 1'b1;
            prev[idx] = 0;
            run[idx]  = 0;
        end else if (prev[idx] == 0) begin
            prev[idx] = int'(c);
            run[idx]  = 1;
        end else if (int'(c) == prev[idx]) begin
            run[idx] = run[idx] + 1;
            stuck = (run[idx] == MAX_DWELL);
        end else begin
            // Legal successor of a one-hot code: shift left, RED wraps to GREEN.
            succ = (prev[idx] == 4) ? 1 : prev[idx] * 2;
            if (int'(c) == succ) begin
                dw  = (prev[idx] == 1 && run[idx] < GREEN_MIN) ||
                      (prev[idx] == 2 && run[idx] != YELLOW_TIME);
                r2g = (prev[idx] == 4);
            end else begin
                trans = 1'b1;
            end
            prev[idx] = int'(c);
            run[idx]  = 1;
        end
    endtask

    // Apply one sample pair across one rising edge; expectations are committed
    // just after the edge so the negedge compare lines up with the DUT.
    task automatic step(input logic [2:0] a, input logic [2:0] b);
        bit          e1, t1, d1, k1, r1, e2, t2, d2, k2, r2, cf;
        logic [4:0]  errs;
        logic        n_valid, n_sticky;
        logic [2:0]  n_first;
        logic [15:0] n_phase;
        s1 = a;
        s2 = b;
        model_signal(0, a, e1, t1, d1, k1, r1);
        model_signal(1, b, e2, t2, d2, k2, r2);
        cf       = is_legal(a) && is_legal(b) && a != R && b != R;
        errs     = {k1 | k2, d1 | d2, t1 | t2, cf, e1 | e2};
        n_valid  = exp_valid | (prev[0] != 0 && prev[1] != 0);
        n_sticky = exp_sticky | (|errs);
        n_first  = exp_first;
        if (!exp_sticky && |errs) begin
            n_first = errs[0] ? 3'd1 : errs[1] ? 3'd2 : errs[2] ? 3'd3 :
                      errs[3] ? 3'd4 : 3'd5;
        end
        n_phase = r1 ? exp_phase + 16'd1 : exp_phase;
        @(posedge clk);
        #1;
        {exp_stuck, exp_dwell, exp_trans, exp_conf, exp_enc} = errs;
        exp_valid  = n_valid;
        exp_sticky = n_sticky;
        exp_first  = n_first;
        exp_phase  = n_phase;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_valid",    monitor_valid,  exp_valid);
            check("cmp_enc",      err_encoding,   exp_enc);
            check("cmp_conflict", err_conflict,   exp_conf);
            check("cmp_trans",    err_transition, exp_trans);
            check("cmp_dwell",    err_dwell,      exp_dwell);
            check("cmp_stuck",    err_stuck,      exp_stuck);
            check("cmp_sticky",   err_sticky,     exp_sticky);
            check("cmp_first",    first_err_code, exp_first);
            check("cmp_phase",    phase_count,    exp_phase);
        end
    end

    int stuck_n, stuck_first_k, stuck_last_k;

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        check("reset_valid", monitor_valid, 0);
        check("reset_sticky", err_sticky, 0);
        check("reset_first", first_err_code, 0);
        check("reset_phase", phase_count, 0);

        // Baseline: signal1 RED, signal2 GREEN.
        step(R, G);
        check("valid_after_first_edge", monitor_valid, 1);
        check("no_conflict_baseline", err_conflict, 0);
        step(R, G);
        step(R, G);

        // Legal signal2 G->Y->R, then signal1 R->G.
        step(R, Y);
        step(R, Y);
        step(R, R);
        step(G, R);
        check("phase_one", phase_count, 1);
        check("legal_run_clean", err_sticky, 0);

        // signal1 YELLOW held 3 samples -> dwell error on Y->R.
        step(G, R);
        step(G, R);
        step(Y, R);
        step(Y, R);
        step(Y, R);
        step(R, R);
        check("dwell_pulse", err_dwell, 1);
        check("dwell_sticky", err_sticky, 1);
        check("dwell_first_code", first_err_code, 4);
        step(R, R);
        check("dwell_pulse_ends", err_dwell, 0);

        // Both GREEN -> conflict; then illegal G->R on signal1.
        step(G, G);
        check("conflict_pulse", err_conflict, 1);
        check("phase_two", phase_count, 2);
        step(R, G);
        check("trans_pulse", err_transition, 1);
        check("conflict_ends", err_conflict, 0);
        check("first_code_held", first_err_code, 4);

        // Illegal code on signal2, re-baseline, then hold RED until stuck.
        step(R, 3'b011);
        check("enc_pulse", err_encoding, 1);
        step(R, R);
        check("rebaseline_no_trans", err_transition, 0);
        check("rebaseline_enc_ends", err_encoding, 0);
        stuck_n       = 0;
        stuck_first_k = 0;
        stuck_last_k  = 0;
        for (int k = 1; k <= 66; k++) begin
            step(R, R);
            if (err_stuck === 1'b1) begin
                stuck_n++;
                if (stuck_first_k == 0) stuck_first_k = k;
                stuck_last_k = k;
            end
        end
        // signal1 reaches 64 samples of RED at k=61, signal2 at k=63.
        check("stuck_pulse_count", stuck_n, 2);
        check("stuck_signal1_edge", stuck_first_k, 61);
        check("stuck_signal2_edge", stuck_last_k, 63);

        // Into YELLOW on signal1, then asynchronous reset mid-cycle.
        step(G, R);
        check("phase_three", phase_count, 3);
        step(G, R);
        step(G, R);
        step(Y, R);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", monitor_valid, 0);
        check("async_sticky", err_sticky, 0);
        check("async_first", first_err_code, 0);
        check("async_phase", phase_count, 0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(R, G);
        check("revalid", monitor_valid, 1);
        step(R, G);
        check("rebaseline_clean", err_sticky, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
